// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the Cessie instruction fetch front end.
package fetch_unit_pkg;

    typedef logic [31:0] bus_type;

    localparam int      INSTR_BYTES      = 4;
    localparam bus_type DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        bus_type pc;
        bus_type word;
    } instr_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head is read straight from storage.
module fetch_queue #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (32'(count_q) == DEPTH);
    assign do_pop  = pop && (count_q != '0) && !flush;
    // A full queue only takes a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !do_pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, response
// queue towards decode, and redirect flush with in-flight response dropping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter bus_type RESET_PC        = DEFAULT_RESET_PC,
    parameter int      QUEUE_DEPTH     = 2,
    parameter int      MAX_OUTSTANDING = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    output logic    imem_req_valid,
    input  logic    imem_req_ready,
    output bus_type imem_req_addr,
    input  logic    imem_rsp_valid,
    input  bus_type imem_rsp_data,
    input  logic    redirect_valid,
    input  bus_type redirect_pc,
    output logic    instr_valid,
    input  logic    instr_ready,
    output bus_type instr,
    output bus_type instr_pc
);

    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);

    bus_type          fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_q, drop_d;

    logic [QCNT_W-1:0] q_count;
    logic [OUT_W-1:0]  tag_count;
    bus_type           tag_pc;
    instr_entry_t      q_head;
    instr_entry_t      q_push_data;
    logic              q_push;
    logic              q_pop;
    logic              req_fire;
    logic [31:0]       credit;

    // Responses still to be dropped will never occupy the queue, so they
    // do not consume credit. Valid is held low while reset is asserted.
    assign credit         = 32'(outstanding_q) - 32'(drop_q) + 32'(q_count);
    assign imem_req_valid = rst_n && (credit < 32'(QUEUE_DEPTH))
                            && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_push      = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign q_pop       = instr_valid && instr_ready && !redirect_valid;
    assign q_push_data = '{pc: tag_pc, word: imem_rsp_data};

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end

        drop_d = drop_q;
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - OUT_W'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        end

        // Everything in flight after this edge, including a request accepted
        // in the redirect cycle, belongs to the abandoned path.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH ($bits(instr_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .count     (q_count),
        .head      (q_head)
    );

    fetch_queue #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .count     (tag_count),
        .head      (tag_pc)
    );

    assign instr_valid = (q_count != '0);
    assign instr       = q_head.word;
    assign instr_pc    = q_head.pc;

    tag_sync_chk: assert property (@(posedge clk) disable iff (!rst_n)
        32'(tag_count) == 32'(outstanding_q));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: in-order variable-latency memory model and
// a scoreboard of expected fetch addresses, restarted on every redirect.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam bus_type RESET_PC = 32'h0000_0000;
    localparam int      MAX_OUT  = 2;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    imem_req_valid;
    logic    imem_req_ready = 1'b0;
    bus_type imem_req_addr;
    logic    imem_rsp_valid = 1'b0;
    bus_type imem_rsp_data = '0;
    logic    redirect_valid = 1'b0;
    bus_type redirect_pc = '0;
    logic    instr_valid;
    logic    instr_ready = 1'b0;
    bus_type instr;
    bus_type instr_pc;

    fetch_unit #(
        .RESET_PC        (RESET_PC),
        .QUEUE_DEPTH     (2),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Memory model: accepted request addresses and the edge their response lands.
    bus_type pend_addr[$];
    int      pend_due[$];
    // Scoreboard: fetch addresses decode should see, in order.
    logic [31:0] exp_q[$];
    bus_type     req_exp;

    int      lat_min = 1, lat_max = 1;
    int      ready_pct = 100, take_pct = 100, redir_permil = 0;
    int      redir_mode = 0;
    bus_type force_tgt = '0;
    bit      redir_fired = 0;
    bit      want_first = 0;
    bus_type first_after = '0;
    bus_type first_pop_pc = '0;
    int      hs_count = 0, pop_count = 0;
    int      first_hs_cyc = -1, first_valid_cyc = -1;

    function automatic bus_type mem_word(input bus_type a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 0);
        check_eq("rst_instr_valid", 32'(instr_valid), 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_instr_pc", instr_pc, 0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_req_valid", 32'(imem_req_valid), 1);
        cyc             = 0;
        req_exp         = RESET_PC;
        hs_count        = 0;
        pop_count       = 0;
        first_hs_cyc    = -1;
        first_valid_cyc = -1;
        redir_fired     = 0;
        want_first      = 0;
    endtask

    // Decide inputs for the coming rising edge, then advance one cycle.
    task automatic step();
        logic    rsp, hs, redir, pop;
        bus_type tgt, e;
        int      lat, inflight;
        inflight = pend_addr.size();
        if (inflight >= MAX_OUT) check_eq("credit_cap", 32'(imem_req_valid), 0);
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        rsp            = (inflight > 0) && (pend_due[0] <= cyc + 1);
        imem_rsp_valid = rsp;
        imem_rsp_data  = $urandom();
        if (rsp) begin
            imem_rsp_data = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end

        imem_req_ready = ($urandom_range(99) < ready_pct);
        hs             = imem_req_valid && imem_req_ready;
        instr_ready    = ($urandom_range(99) < take_pct);

        tgt   = $urandom();
        redir = ($urandom_range(999) < redir_permil);
        if ((redir_mode == 1 && inflight == MAX_OUT) || (redir_mode == 2 && rsp && hs)
            || redir_mode == 3) begin
            redir       = 1'b1;
            tgt         = force_tgt;
            redir_mode  = 0;
            redir_fired = 1;
            want_first  = 1;
        end
        redirect_valid = redir;
        redirect_pc    = tgt;

        if (hs) begin
            hs_count++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc + 1;
            lat = $urandom_range(lat_max, lat_min);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + 1 + lat);
            if (!redir) begin
                check_eq("req_addr", imem_req_addr, req_exp);
                exp_q.push_back(req_exp);
                req_exp += 32'd4;
            end
        end

        pop = instr_valid && instr_ready && !redir;
        if (pop) begin
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("instr_pc", instr_pc, e);
                check_eq("instr_word", instr, mem_word(e));
            end
            if (pop_count == 0) first_pop_pc = instr_pc;
            pop_count++;
            if (want_first) begin
                first_after = instr_pc;
                want_first  = 0;
            end
        end

        if (redir) begin
            exp_q.delete();
            req_exp = {tgt[31:2], 2'b00};
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        // Streaming with a 1-cycle memory and decode always ready.
        apply_reset();
        run(20);
        check_eq("first_hs_cyc", 32'(first_hs_cyc), 1);
        check_eq("first_valid_cyc", 32'(first_valid_cyc), 32'(first_hs_cyc + 1));
        check_eq("stream_pops", 32'(pop_count >= 8), 1);

        // Decode stalled: two requests fill the queue, then issue stops.
        take_pct = 0;
        apply_reset();
        run(10);
        check_eq("stall_hs", 32'(hs_count), 2);
        check_eq("stall_req_valid", 32'(imem_req_valid), 0);
        check_eq("stall_instr_valid", 32'(instr_valid), 1);
        check_eq("stall_head_pc", instr_pc, RESET_PC);
        check_eq("stall_head_word", instr, mem_word(RESET_PC));
        take_pct = 100;
        run(10);
        check_eq("stall_resume", 32'(hs_count > 2), 1);

        // Redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        apply_reset();
        redir_mode = 1; force_tgt = 32'h0000_1003;
        run(30);
        check_eq("redir2_fired", 32'(redir_fired), 1);
        check_eq("redir2_first_pc", first_after, 32'h0000_1000);

        // Redirect coinciding with a request handshake and a response.
        lat_min = 1; lat_max = 1;
        apply_reset();
        redir_mode = 2; force_tgt = 32'h0000_2002;
        run(20);
        check_eq("redir_both_fired", 32'(redir_fired), 1);
        check_eq("redir_both_first_pc", first_after, 32'h0000_2000);

        // Fetch PC wraps past the top of the address space.
        apply_reset();
        redir_mode = 3; force_tgt = 32'hFFFF_FFF9;
        run(20);
        check_eq("wrap_first_pc", first_after, 32'hFFFF_FFF8);
        check_eq("wrap_pops", 32'(pop_count >= 4), 1);

        // Random ready, latency and redirects.
        lat_min = 1; lat_max = 5;
        ready_pct = 70; take_pct = 60; redir_permil = 30;
        apply_reset();
        run(3000);
        check_eq("rand_progress", 32'(pop_count > 100), 1);

        // Reset asserted mid-operation with the queue full.
        lat_min = 1; lat_max = 1;
        ready_pct = 100; take_pct = 0; redir_permil = 0;
        apply_reset();
        run(8);
        check_eq("pre_rst_full", 32'(instr_valid), 1);
        #2;
        apply_reset();
        take_pct = 100;
        run(20);
        check_eq("post_rst_pops", 32'(pop_count >= 5), 1);
        check_eq("post_rst_first_pc", first_pop_pc, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
